// File: rtl/axi_hs_pkg.sv
// Shared types and default parameters for the stream_master burst source
// and its stall-timeout counter.
package axi_hs_pkg;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_LEN_W     = 8;
    localparam int DEF_TIMEOUT   = 16;
    localparam int TIMEOUT_CNT_W = 16;  // holds any TIMEOUT in 1..65535

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

endpackage

// File: rtl/hs_timeout_cnt.sv
// Consecutive-stall counter: counts inc cycles, clears on clr, and flags the
// stalled cycle that brings the count up to TIMEOUT.
module hs_timeout_cnt
    import axi_hs_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam logic [TIMEOUT_CNT_W-1:0] LAST_CNT = TIMEOUT_CNT_W'(TIMEOUT - 1);

    logic [TIMEOUT_CNT_W-1:0] cnt_q;
    logic [TIMEOUT_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + TIMEOUT_CNT_W'(1);
        end
    end

    // Fires on the stalled cycle that completes TIMEOUT stalls, so the owner
    // can leave SEND on that same edge.
    assign expired = inc && !clr && (cnt_q == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stream_master.sv
// Burst source: on start emits len incrementing words from seed over a
// valid/ready handshake, pulsing done on completion or err on stall timeout.
module stream_master
    import axi_hs_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] seed,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    logic transfer;
    logic stall_clr;
    logic stall_inc;
    logic stall_expired;

    assign transfer  = valid_q && ready;
    assign stall_inc = (state_q == ST_SEND) && !ready;
    assign stall_clr = (state_q != ST_SEND) || transfer;

    hs_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (stall_clr),
        .inc     (stall_inc),
        .expired (stall_expired)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d     = state_q;
        data_d      = data_q;
        remaining_d = remaining_q;
        valid_d     = valid_q;
        err_d       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // The IDLE cycle carrying the err pulse still refuses a start.
                if (start && !err_q) begin
                    if (len != '0) begin
                        state_d     = ST_SEND;
                        data_d      = seed;
                        remaining_d = len;
                        valid_d     = 1'b1;
                    end else begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_SEND: begin
                if (transfer) begin
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = ST_FINISH;
                        valid_d = 1'b0;
                    end else begin
                        data_d      = data_q + DATA_W'(1);
                        remaining_d = remaining_q - LEN_W'(1);
                    end
                end else if (stall_expired) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    err_d   = 1'b1;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            remaining_q <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            remaining_q <= remaining_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    // All outputs come straight from flops: no combinational ready-to-valid path.
    assign valid = valid_q;
    assign data  = data_q;
    assign busy  = (state_q != ST_IDLE);
    assign done  = (state_q == ST_FINISH);
    assign err   = err_q;

endmodule

// File: tb/tb_stream_master.sv
// Directed self-checking bench for stream_master: basic burst, back-pressure,
// timeout, len=0, data wrap, mid-burst reset, start-while-busy, falling-edge ready.
module tb_stream_master;

    localparam int DATA_W  = 32;
    localparam int LEN_W   = 8;
    localparam int TIMEOUT = 16;

    logic              clk;
    logic              rst;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] seed;
    logic              ready;
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              busy;
    logic              done;
    logic              err;

    int n_cmp;
    int n_err;
    int done_cnt;
    int err_cnt;
    logic [DATA_W-1:0] log_q[$];

    stream_master #(
        .DATA_W  (DATA_W),
        .LEN_W   (LEN_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .len   (len),
        .seed  (seed),
        .ready (ready),
        .valid (valid),
        .data  (data),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream-side monitor: records accepted beats and counts pulses.
    always @(posedge clk) begin
        if (!rst) begin
            if (valid && ready) log_q.push_back(data);
            if (done) done_cnt <= done_cnt + 1;
            if (err)  err_cnt  <= err_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [LEN_W-1:0] l, input logic [DATA_W-1:0] s);
        start = 1'b1;
        len   = l;
        seed  = s;
        tick();
        start = 1'b0;
    endtask

    task automatic check_log(input string tag, input logic [DATA_W-1:0] first, input int n);
        check({tag, "_beats"}, 64'(log_q.size()), 64'(n));
        for (int i = 0; i < n && i < log_q.size(); i++) begin
            check($sformatf("%s_beat%0d", tag, i), 64'(log_q[i]), 64'(first + DATA_W'(i)));
        end
    endtask

    initial begin
        int d0;
        int e0;
        logic got_done;
        logic [7:0] pat;

        n_cmp = 0; n_err = 0; done_cnt = 0; err_cnt = 0;
        rst = 1'b1; start = 1'b1; len = 8'd4; seed = 32'h55; ready = 1'b1;

        // Reset state, start ignored while rst is high.
        repeat (3) tick();
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_busy",  64'(busy),  64'd0);
        check("rst_done",  64'(done),  64'd0);
        check("rst_err",   64'(err),   64'd0);
        check("rst_data",  64'(data),  64'd0);
        rst = 1'b0; start = 1'b0;
        tick();
        check("post_rst_busy", 64'(busy), 64'd0);

        // Basic burst: len=4, seed=0x10, ready always high.
        log_q.delete(); d0 = done_cnt;
        pulse_start(8'd4, 32'h10);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("basic_data%0d", i),  64'(data),  64'(32'h10 + i));
            check($sformatf("basic_valid%0d", i), 64'(valid), 64'd1);
            check($sformatf("basic_done%0d", i),  64'(done),  64'd0);
            tick();
        end
        check("basic_valid_fall", 64'(valid), 64'd0);
        check("basic_done",       64'(done),  64'd1);
        check("basic_busy_fin",   64'(busy),  64'd1);
        tick();
        check("basic_done_1cyc",  64'(done),  64'd0);
        check("basic_busy_idle",  64'(busy),  64'd0);
        check("basic_done_cnt",   64'(done_cnt - d0), 64'd1);
        check_log("basic", 32'h10, 4);

        // Back-pressure: stall 5 cycles before beat 2.
        log_q.delete(); e0 = err_cnt;
        pulse_start(8'd3, 32'h40);
        check("bp_data0", 64'(data), 64'h40);
        tick();
        check("bp_data1", 64'(data), 64'h41);
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp_hold%0d", i),  64'(data),  64'h41);
            check($sformatf("bp_valid%0d", i), 64'(valid), 64'd1);
        end
        ready = 1'b1;
        tick();
        check("bp_data2", 64'(data), 64'h42);
        tick();
        check("bp_done", 64'(done), 64'd1);
        tick();
        check("bp_no_err", 64'(err_cnt - e0), 64'd0);
        check_log("bp", 32'h40, 3);

        // Timeout: ready held low, err after TIMEOUT stalled cycles.
        d0 = done_cnt; e0 = err_cnt;
        ready = 1'b0;
        pulse_start(8'd2, 32'h5);
        for (int i = 1; i < TIMEOUT; i++) begin
            tick();
            check($sformatf("to_wait_err%0d", i), 64'(err), 64'd0);
        end
        check("to_valid_before", 64'(valid), 64'd1);
        tick();
        check("to_err",        64'(err),   64'd1);
        check("to_valid_low",  64'(valid), 64'd0);
        check("to_busy_low",   64'(busy),  64'd0);
        start = 1'b1; len = 8'd1; seed = 32'h9;
        tick();
        start = 1'b0;
        check("to_err_1cyc",      64'(err),   64'd0);
        check("to_start_ignored", 64'(busy),  64'd0);
        check("to_valid_still",   64'(valid), 64'd0);
        check("to_err_cnt",  64'(err_cnt - e0),  64'd1);
        check("to_no_done",  64'(done_cnt - d0), 64'd0);
        ready = 1'b1;
        tick();

        // len=0: done pulse, valid never raised; start during done ignored.
        log_q.delete();
        pulse_start(8'd0, 32'h77);
        check("len0_done",  64'(done),  64'd1);
        check("len0_valid", 64'(valid), 64'd0);
        start = 1'b1; len = 8'd2;
        tick();
        start = 1'b0;
        check("len0_done_1cyc",    64'(done),  64'd0);
        check("len0_start_ignored", 64'(busy), 64'd0);
        check("len0_valid_after",  64'(valid), 64'd0);
        check("len0_beats", 64'(log_q.size()), 64'd0);

        // Data wrap from all-ones to zero.
        pulse_start(8'd2, 32'hFFFF_FFFF);
        check("wrap_data0", 64'(data), 64'hFFFF_FFFF);
        tick();
        check("wrap_data1",  64'(data),  64'h0);
        check("wrap_valid1", 64'(valid), 64'd1);
        tick();
        check("wrap_done", 64'(done), 64'd1);
        tick();

        // Reset mid-burst at beat 2 of len=8, then a normal len=1 burst.
        log_q.delete(); d0 = done_cnt; e0 = err_cnt;
        pulse_start(8'd8, 32'h100);
        tick();
        check("mrst_beat2", 64'(data), 64'h101);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_valid", 64'(valid), 64'd0);
        check("mrst_busy",  64'(busy),  64'd0);
        check("mrst_data",  64'(data),  64'd0);
        tick();
        check("mrst_no_done", 64'(done_cnt - d0), 64'd0);
        check("mrst_no_err",  64'(err_cnt - e0),  64'd0);
        log_q.delete();
        pulse_start(8'd1, 32'hAB);
        check("mrst_new_data", 64'(data), 64'hAB);
        tick();
        check("mrst_new_done", 64'(done), 64'd1);
        tick();
        check_log("mrst_new", 32'hAB, 1);

        // Start while busy is ignored.
        log_q.delete();
        pulse_start(8'd3, 32'h200);
        start = 1'b1; len = 8'd9; seed = 32'h999;
        tick();
        start = 1'b0;
        check("busy_start_data1", 64'(data), 64'h201);
        tick();
        check("busy_start_data2", 64'(data), 64'h202);
        tick();
        check("busy_start_done", 64'(done), 64'd1);
        tick();
        check_log("busy_start", 32'h200, 3);

        // Downstream stage driving ready on the falling edge.
        log_q.delete(); e0 = err_cnt;
        pat = 8'b1011_0010;
        ready = 1'b0;
        pulse_start(8'd5, 32'h30);
        got_done = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            ready = pat[cyc % 8];
            tick();
            if (done) begin
                got_done = 1'b1;
                break;
            end
        end
        check("pair_done", 64'(got_done), 64'd1);
        check("pair_no_err", 64'(err_cnt - e0), 64'd0);
        check_log("pair", 32'h30, 5);

        ready = 1'b1;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
